nes_joypad_responder: RTL and testbench



---
 rtl/nes_joypad_responder.sv | 123 ++++++++++++
 tb/tb_nes_joypad_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_joypad_responder.sv
// NES controller (4021-style) emulation: samples board button levels and serves them serially to the console.
// Optional latch-driven turbo on A/B is enabled by defining NES_JOYPAD_TURBO_EN.
module nes_joypad_responder #(
  parameter int SYNC_STAGES   = 2,
  parameter bit INVERT_DATA   = 1'b1,
  parameter int TURBO_LATCHES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] buttons,
  input  logic [1:0] turbo_sel,
  input  logic       jp_latch,
  input  logic       jp_clk,
  output logic       jp_data,
  output logic [3:0] bit_idx
);

  typedef enum logic [1:0] {LOAD, SHIFT, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] latch_sync_reg, clk_sync_reg;
  logic                   clk_prev_reg;
  logic                   latch_s, clk_s, clk_rise;
  logic [7:0]             shift_reg, shift_next;
  logic [3:0]             bit_idx_reg, bit_idx_next;
  logic                   jp_data_reg, jp_data_next;
  logic [7:0]             load_value;

  assign latch_s  = latch_sync_reg[SYNC_STAGES-1];
  assign clk_s    = clk_sync_reg[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_sync_reg <= '0;
      clk_sync_reg   <= '0;
      clk_prev_reg   <= 1'b0;
      state_reg      <= LOAD;
      shift_reg      <= 8'h00;
      bit_idx_reg    <= 4'd0;
      jp_data_reg    <= INVERT_DATA;
    end else begin
      latch_sync_reg <= {latch_sync_reg[SYNC_STAGES-2:0], jp_latch};
      clk_sync_reg   <= {clk_sync_reg[SYNC_STAGES-2:0], jp_clk};
      clk_prev_reg   <= clk_s;
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      bit_idx_reg    <= bit_idx_next;
      jp_data_reg    <= jp_data_next;
    end
  end

`ifdef NES_JOYPAD_TURBO_EN
  localparam logic [7:0] TURBO_WRAP = 8'(TURBO_LATCHES - 1);

  logic       latch_prev_reg;
  logic       latch_rise;
  logic [7:0] turbo_cnt_reg;
  logic       turbo_phase_reg;
  logic       frame_phase_reg;
  logic       load_phase;

  assign latch_rise = latch_s & ~latch_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_prev_reg  <= 1'b0;
      turbo_cnt_reg   <= 8'd0;
      turbo_phase_reg <= 1'b0;
      frame_phase_reg <= 1'b0;
    end else begin
      latch_prev_reg <= latch_s;
      if (latch_rise) begin
        frame_phase_reg <= turbo_phase_reg;
        if (turbo_cnt_reg == TURBO_WRAP) begin
          turbo_cnt_reg   <= 8'd0;
          turbo_phase_reg <= ~turbo_phase_reg;
        end else begin
          turbo_cnt_reg <= turbo_cnt_reg + 8'd1;
        end
      end
    end
  end

  // A frame is masked with the phase in force before its own latch edge advanced the counter.
  assign load_phase = latch_rise ? turbo_phase_reg : frame_phase_reg;
  assign load_value = buttons & ~{6'b000000, turbo_sel & {2{load_phase}}};
`else
  logic turbo_unused;
  assign turbo_unused = ^{turbo_sel, 8'(TURBO_LATCHES)};
  assign load_value   = buttons;
`endif

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_idx_next = bit_idx_reg;
    if (latch_s) begin
      state_next   = LOAD;
      shift_next   = load_value;
      bit_idx_next = 4'd0;
    end else begin
      case (state_reg)
        LOAD:  state_next = SHIFT;
        SHIFT: begin
          if (clk_rise) begin
            shift_next   = {1'b0, shift_reg[7:1]};
            bit_idx_next = bit_idx_reg + 4'd1;
            if (bit_idx_reg == 4'd7) state_next = DONE;
          end
        end
        DONE:    state_next = DONE;
        default: state_next = LOAD;
      endcase
    end
    // Past the eighth bit the line idles low, as the real part does with its serial input grounded.
    jp_data_next = (bit_idx_reg == 4'd8) ? 1'b0 : (shift_reg[0] ^ INVERT_DATA);
  end

  assign jp_data = jp_data_reg;
  assign bit_idx = bit_idx_reg;

endmodule

// File: tb/tb_nes_joypad_responder.sv
// Randomized scoreboard bench for nes_joypad_responder; expected pin levels come from a frame/bit-position model.
module tb_nes_joypad_responder;
  localparam int SYNC_STAGES   = 2;
  localparam bit INVERT_DATA   = 1'b1;
  localparam int TURBO_LATCHES = 2;
  localparam int LAT           = SYNC_STAGES + 2;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic [7:0] buttons   = 8'h00;
  logic [1:0] turbo_sel = 2'b00;
  logic       jp_latch  = 1'b0;
  logic       jp_clk    = 1'b0;
  logic       jp_data;
  logic [3:0] bit_idx;

  nes_joypad_responder #(
    .SYNC_STAGES  (SYNC_STAGES),
    .INVERT_DATA  (INVERT_DATA),
    .TURBO_LATCHES(TURBO_LATCHES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .buttons  (buttons),
    .turbo_sel(turbo_sel),
    .jp_latch (jp_latch),
    .jp_clk   (jp_clk),
    .jp_data  (jp_data),
    .bit_idx  (bit_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic       d;
    logic [3:0] idx;
    int         tag;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   tag_ctr = 0;

  // Reference model: the frame the console is reading and how many bits it has consumed.
  logic [7:0] frame_bits  = 8'h00;
  int         frame_pos   = 0;
  int         latch_count = 0;
  logic       cur_d       = INVERT_DATA;

  function automatic logic model_data();
    return (frame_pos < 8) ? (frame_bits[frame_pos] ^ INVERT_DATA) : 1'b0;
  endfunction

  function automatic void sb_insert(input exp_t e);
    int i = 0;
    while (i < sbq.size() && sbq[i].due <= e.due) i++;
    sbq.insert(i, e);
  endfunction

  function automatic void expect_at(input int due, input logic d, input logic [3:0] idx);
    exp_t e;
    e.due = due; e.d = d; e.idx = idx; e.tag = tag_ctr;
    tag_ctr++;
    sb_insert(e);
  endfunction

  // A pin edge now must leave jp_data unchanged one cycle short of LAT, and updated exactly at LAT.
  function automatic void schedule(input logic new_d, input logic [3:0] new_idx);
    expect_at(cyc + LAT - 1, cur_d, new_idx);
    expect_at(cyc + LAT, new_d, new_idx);
    cur_d = new_d;
  endfunction

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      mon_e = sbq.pop_front();
      checks++;
      if (mon_e.due != cyc) begin
        errors++;
        $display("FAIL sb%0d missed: due cycle %0d, seen at %0d", mon_e.tag, mon_e.due, cyc);
      end else if (jp_data !== mon_e.d || bit_idx !== mon_e.idx) begin
        errors++;
        $display("FAIL sb%0d cycle %0d: jp_data=%b bit_idx=%0d, required jp_data=%b bit_idx=%0d",
                 mon_e.tag, cyc, jp_data, bit_idx, mon_e.d, mon_e.idx);
      end else begin
        $display("sb%0d cycle %0d jp_data=%b bit_idx=%0d ok", mon_e.tag, cyc, jp_data, bit_idx);
      end
    end
  end

  task automatic check_now(input string name, input logic d, input logic [3:0] idx);
    checks++;
    if (jp_data !== d || bit_idx !== idx) begin
      errors++;
      $display("FAIL %s: jp_data=%b bit_idx=%0d, required jp_data=%b bit_idx=%0d", name, jp_data, bit_idx, d, idx);
    end else begin
      $display("%s jp_data=%b bit_idx=%0d ok", name, jp_data, bit_idx);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations still pending, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  function automatic void model_load(input logic [7:0] b, input logic [1:0] ts);
    frame_bits = b;
`ifdef NES_JOYPAD_TURBO_EN
    if (((latch_count / TURBO_LATCHES) % 2) == 1) frame_bits = b & ~{6'b000000, ts};
`else
    if (ts != 2'b00) frame_bits = b;
`endif
    latch_count++;
    frame_pos = 0;
  endfunction

  task automatic latch_pulse(input logic [7:0] b, input logic [1:0] ts, input int width);
    buttons   = b;
    turbo_sel = ts;
    jp_latch  = 1'b1;
    model_load(b, ts);
    schedule(model_data(), 4'd0);
    repeat (width) @(negedge clk);
    jp_latch = 1'b0;
    repeat (LAT) @(negedge clk);
  endtask

  task automatic clk_pulse(input int hi, input int lo);
    jp_clk = 1'b1;
    if (frame_pos < 8) frame_pos++;
    schedule(model_data(), 4'(frame_pos));
    repeat (hi) @(negedge clk);
    jp_clk = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic random_pulses(input int n);
    for (int i = 0; i < n; i++) clk_pulse($urandom_range(3, 8), $urandom_range(3, 8));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_now("reset_hold", INVERT_DATA, 4'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      expect_at(cyc + 1, INVERT_DATA, 4'd0);
      @(negedge clk);
    end
    wait_drain();

    // Directed frame, mid-frame button change, over-clocking past bit 8.
    latch_pulse(8'b1000_0101, 2'b00, 4);
    buttons = 8'hFF;
    repeat (8) clk_pulse(6, 6);
    repeat (3) clk_pulse(6, 6);
    latch_pulse(8'hFF, 2'b00, 4);
    repeat (8) clk_pulse(6, 6);

    // jp_clk edge while latch is still high is discarded.
    buttons  = 8'($urandom);
    jp_latch = 1'b1;
    model_load(buttons, 2'b00);
    schedule(model_data(), 4'd0);
    repeat (4) @(negedge clk);
    jp_clk = 1'b1;
    schedule(cur_d, 4'd0);
    repeat (3) @(negedge clk);
    jp_clk = 1'b0;
    repeat (4) @(negedge clk);
    jp_latch = 1'b0;
    repeat (LAT) @(negedge clk);
    random_pulses(8);

    // Latch and jp_clk rising together at bit 3: latch wins.
    latch_pulse(8'($urandom), 2'b00, 5);
    random_pulses(3);
    buttons  = 8'($urandom);
    jp_latch = 1'b1;
    jp_clk   = 1'b1;
    model_load(buttons, 2'b00);
    schedule(model_data(), 4'd0);
    repeat (5) @(negedge clk);
    jp_clk = 1'b0;
    repeat (3) @(negedge clk);
    jp_latch = 1'b0;
    repeat (LAT) @(negedge clk);
    random_pulses(8);

    // Reset at bit 5, then a clean frame.
    latch_pulse(8'($urandom), 2'b00, 4);
    random_pulses(5);
    wait_drain();
    #1 rst_n = 1'b0;
    #1 check_now("reset_async", INVERT_DATA, 4'd0);
    frame_bits  = 8'h00;
    frame_pos   = 0;
    latch_count = 0;
    cur_d       = INVERT_DATA;
    repeat (2) @(negedge clk);
    check_now("reset_mid", INVERT_DATA, 4'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    latch_pulse(8'h01, 2'b00, 4);
    repeat (8) clk_pulse(6, 6);

`ifdef NES_JOYPAD_TURBO_EN
    for (int f = 0; f < 6; f++) begin
      latch_pulse(8'h03, 2'b01, 4);
      clk_pulse(4, 4);
    end
`endif

    for (int f = 0; f < 12; f++) begin
      latch_pulse(8'($urandom), 2'($urandom), $urandom_range(3, 8));
      buttons = 8'($urandom);
      random_pulses($urandom_range(6, 11));
    end

    wait_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
